fpu_addsub_core: RTL and testbench

- Multi-cycle add/subtract datapath sitting directly downstream of the FPU pre-normalisation stage.
- Consumes the unpacked 33-bit operands and the 3-bit exception code that pre-normalisation produces.
- Performs exponent alignment, mantissa add/sub, normalisation and round-to-nearest-even.
- Returns a packed IEEE-754 single-precision result with status flags to the FPU writeback mux, using a start/done handshake.

---
 rtl/fpu_addsub_core.sv | 199 +++++++++++++++++++
 tb/tb_fpu_addsub_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_core.sv
// Multi-cycle IEEE-754 single-precision add/subtract core fed by the FPU pre-normalisation stage.
// Flow: capture -> align -> add/sub -> normalise (one left shift per cycle) -> round-to-nearest-even -> done.
module fpu_addsub_core #(
    parameter int NORM_MAX = 26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [32:0] pre_a_i,
    input  logic [32:0] pre_b_i,
    input  logic [2:0]  exception_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        invalid_o,
    output logic        inexact_o
);
    localparam int CNT_W = $clog2(NORM_MAX + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state, state_nxt;

    logic             sign_a, sign_b, sign_r, eff_sub;
    logic [7:0]       exp_a, exp_b;
    logic [23:0]      man_a, man_b;
    logic [9:0]       exp_r;
    logic [26:0]      ma_r, mb_r;
    logic [27:0]      mant_r;
    logic [CNT_W-1:0] shift_cnt;

    logic        a_big;
    logic [7:0]  big_exp, small_exp;
    logic [23:0] big_man, small_man;
    logic [27:0] sum;
    logic        sum_zero, norm_flush, grs, rnd_ovf;
    logic [24:0] rnd;
    logic [9:0]  rnd_exp;
    logic [31:0] rnd_res, spec_res;
    logic        spec_inv;

    // Right shift that folds every bit pushed past the LSB into the sticky position.
    function automatic logic [26:0] align_shift(input logic [26:0] m, input logic [7:0] d);
        logic [26:0] mask;
        if (d >= 8'd27) return {26'd0, |m};
        mask = (27'd1 << d) - 27'd1;
        return (m >> d) | {26'd0, |(m & mask)};
    endfunction

    function automatic logic [24:0] round_rne(input logic [26:0] m);
        logic inc;
        inc = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[26:3]} + {24'd0, inc};
    endfunction

    always_comb begin
        spec_res = QNAN;
        spec_inv = 1'b1;
        case (exception_i)
            3'd1: begin spec_res = {pre_a_i[32:24], pre_a_i[22:0]}; spec_inv = 1'b0; end
            3'd2: begin spec_res = {pre_b_i[32:24], pre_b_i[22:0]}; spec_inv = 1'b0; end
            3'd3: if (pre_a_i[32] == pre_b_i[32]) begin
                spec_res = {pre_a_i[32], 8'hFF, 23'd0};
                spec_inv = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_big     = {exp_a, man_a} >= {exp_b, man_b};
        big_exp   = a_big ? exp_a : exp_b;
        small_exp = a_big ? exp_b : exp_a;
        big_man   = a_big ? man_a : man_b;
        small_man = a_big ? man_b : man_a;
        sum       = eff_sub ? ({1'b0, ma_r} - {1'b0, mb_r}) : ({1'b0, ma_r} + {1'b0, mb_r});
        sum_zero  = (sum == 28'd0);
        // A shift that would take the exponent to 0 means the result is subnormal.
        norm_flush = (exp_r <= 10'd1) || (shift_cnt == CNT_W'(NORM_MAX));
        rnd       = round_rne(mant_r[26:0]);
        rnd_exp   = exp_r + {9'd0, rnd[24]};
        grs       = |mant_r[2:0];
        rnd_ovf   = (rnd_exp >= 10'd255);
        rnd_res   = rnd_ovf ? {sign_r, 8'hFF, 23'd0}
                  : {sign_r, rnd_exp[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) state_nxt = (exception_i == 3'd0) ? ALIGN : DONE;
            end
            ALIGN: state_nxt = ADD;
            ADD:   state_nxt = sum_zero ? DONE : NORM;
            NORM: begin
                if (mant_r[27] || mant_r[26]) state_nxt = ROUND;
                else if (norm_flush)          state_nxt = DONE;
            end
            ROUND: state_nxt = DONE;
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        case (state)
            // capture: denormal operands are flushed to zero here
            IDLE: if (start_i) begin
                sign_a <= pre_a_i[32];
                sign_b <= pre_b_i[32];
                exp_a  <= pre_a_i[31:24];
                exp_b  <= pre_b_i[31:24];
                man_a  <= (pre_a_i[31:24] == 8'd0) ? 24'd0 : pre_a_i[23:0];
                man_b  <= (pre_b_i[31:24] == 8'd0) ? 24'd0 : pre_b_i[23:0];
            end
            // align: larger magnitude first, smaller shifted into {G,R,S}
            ALIGN: begin
                sign_r  <= a_big ? sign_a : sign_b;
                eff_sub <= sign_a ^ sign_b;
                exp_r   <= {2'b00, big_exp};
                ma_r    <= {big_man, 3'b000};
                mb_r    <= align_shift({small_man, 3'b000}, big_exp - small_exp);
            end
            // add/sub
            ADD: begin
                mant_r    <= sum;
                shift_cnt <= '0;
            end
            // normalise
            NORM: begin
                if (mant_r[27]) begin
                    mant_r <= {1'b0, mant_r[27:2], |mant_r[1:0]};
                    exp_r  <= exp_r + 10'd1;
                end else if (!mant_r[26] && !norm_flush) begin
                    mant_r    <= {mant_r[26:0], 1'b0};
                    exp_r     <= exp_r - 10'd1;
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            invalid_o   <= 1'b0;
            inexact_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && exception_i != 3'd0) begin
                    result_o    <= spec_res;
                    overflow_o  <= 1'b0;
                    underflow_o <= 1'b0;
                    invalid_o   <= spec_inv;
                    inexact_o   <= 1'b0;
                end
                ADD: if (sum_zero) begin
                    result_o    <= {sign_r & ~eff_sub, 31'd0};
                    overflow_o  <= 1'b0;
                    underflow_o <= 1'b0;
                    invalid_o   <= 1'b0;
                    inexact_o   <= 1'b0;
                end
                NORM: if (!mant_r[27] && !mant_r[26] && norm_flush) begin
                    result_o    <= {sign_r, 31'd0};
                    overflow_o  <= 1'b0;
                    underflow_o <= 1'b1;
                    invalid_o   <= 1'b0;
                    inexact_o   <= 1'b1;
                end
                ROUND: begin
                    result_o    <= rnd_res;
                    overflow_o  <= rnd_ovf;
                    underflow_o <= 1'b0;
                    invalid_o   <= 1'b0;
                    inexact_o   <= rnd_ovf | grs;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_core.sv
// Bench for fpu_addsub_core: directed vector table, hand sequences for busy/reset, and random
// operations checked against an exact-integer IEEE add model.
module tb_fpu_addsub_core;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic [32:0] pre_a_i, pre_b_i;
    logic [2:0]  exception_i;
    logic        ready_o, done_o, overflow_o, underflow_o, invalid_o, inexact_o;
    logic [31:0] result_o;

    fpu_addsub_core #(.NORM_MAX(26)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .pre_a_i(pre_a_i), .pre_b_i(pre_b_i), .exception_i(exception_i),
        .ready_o(ready_o), .done_o(done_o), .result_o(result_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o),
        .invalid_o(invalid_o), .inexact_o(inexact_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [32:0] a;
        logic [32:0] b;
        logic [2:0]  code;
        logic [31:0] res;
        logic [3:0]  flg;   // {overflow, underflow, invalid, inexact}
        int          lat;   // 0 = latency not checked
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [32:0] pk(input logic [31:0] f);
        return {f[31], f[30:23], (f[30:23] != 8'd0), f[22:0]};
    endfunction

    // Exact reference: operands become integers scaled by 2^149, summed exactly, then rounded RNE.
    function automatic logic [35:0] ref_model(input logic [32:0] a, input logic [32:0] b,
                                              input logic [2:0] code);
        logic [299:0] xa, xb, mag, mant, rem, half;
        logic         sr, inx;
        int           ea, eb, p, sh, e;
        case (code)
            3'd0: ;
            3'd1: return {a[32], a[31:24], a[22:0], 4'b0000};
            3'd2: return {b[32], b[31:24], b[22:0], 4'b0000};
            3'd3: if (a[32] == b[32]) return {a[32], 8'hFF, 23'd0, 4'b0000};
                  else return {32'h7FC00000, 4'b0010};
            default: return {32'h7FC00000, 4'b0010};
        endcase
        ea = int'(a[31:24]);
        eb = int'(b[31:24]);
        xa = (ea == 0) ? '0 : (300'(a[23:0]) << (ea - 1));
        xb = (eb == 0) ? '0 : (300'(b[23:0]) << (eb - 1));
        if (a[32] == b[32])  begin mag = xa + xb; sr = a[32]; end
        else if (xa >= xb)   begin mag = xa - xb; sr = a[32]; end
        else                 begin mag = xb - xa; sr = b[32]; end
        if (mag == '0) return {(a[32] == b[32]) ? a[32] : 1'b0, 31'd0, 4'b0000};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e < 1) return {sr, 31'd0, 4'b0101};
        sh   = p - 23;
        mant = mag >> sh;
        rem  = mag - (mant << sh);
        inx  = (rem != '0);
        if (sh > 0) begin
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 300'(1);
        end
        if (mant[24]) begin mant = mant >> 1; e = e + 1; end
        if (e >= 255) return {sr, 8'hFF, 23'd0, 4'b1001};
        return {sr, 8'(e), mant[22:0], 3'b000, inx};
    endfunction

    task automatic run_op(input logic [32:0] a, input logic [32:0] b, input logic [2:0] code,
                          input bit noise, output logic [31:0] res, output logic [3:0] flg,
                          output int lat, output bit ok);
        int w;
        w = 0;
        @(negedge clk_i);
        while (!ready_o && w < 100) begin @(negedge clk_i); w++; end
        pre_a_i = a; pre_b_i = b; exception_i = code; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 1;
        ok  = 1'b0;
        while (lat <= 60) begin
            if (done_o) begin ok = 1'b1; break; end
            start_i = noise && (lat % 7 == 3);
            if (start_i) begin
                pre_a_i = {$urandom, 1'b1}; pre_b_i = {$urandom, 1'b0}; exception_i = 3'd4;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        start_i = 1'b0;
        res = result_o;
        flg = {overflow_o, underflow_o, invalid_o, inexact_o};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [3:0]  flg;
        logic [35:0] exp_v;
        logic [32:0] a, b;
        logic [2:0]  code;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        int          lat, extra, mode, t;
        bit          ok;

        vecs[0]  = '{pk(32'h3F800000), pk(32'h3F800000), 3'd0, 32'h40000000, 4'b0000, 5};
        vecs[1]  = '{pk(32'h3F800000), pk(32'hBF800000), 3'd0, 32'h00000000, 4'b0000, 3};
        vecs[2]  = '{pk(32'h3F800000), pk(32'h40000000), 3'd4, 32'h7FC00000, 4'b0010, 1};
        vecs[3]  = '{pk(32'hFF800000), pk(32'hFF800000), 3'd3, 32'hFF800000, 4'b0000, 1};
        vecs[4]  = '{pk(32'h7F800000), pk(32'hFF800000), 3'd3, 32'h7FC00000, 4'b0010, 1};
        vecs[5]  = '{pk(32'h40490FDB), pk(32'h3F800000), 3'd1, 32'h40490FDB, 4'b0000, 1};
        vecs[6]  = '{pk(32'h3F800000), pk(32'hC0000000), 3'd2, 32'hC0000000, 4'b0000, 1};
        vecs[7]  = '{pk(32'h3F800000), pk(32'h3F800000), 3'd6, 32'h7FC00000, 4'b0010, 1};
        vecs[8]  = '{pk(32'h3F800000), pk(32'h33800000), 3'd0, 32'h3F800000, 4'b0001, 5};
        vecs[9]  = '{pk(32'h3F800000), pk(32'h33C00000), 3'd0, 32'h3F800001, 4'b0001, 5};
        vecs[10] = '{pk(32'h7F7FFFFF), pk(32'h7F7FFFFF), 3'd0, 32'h7F800000, 4'b1001, 5};
        vecs[11] = '{pk(32'h40000000), pk(32'hBF000000), 3'd0, 32'h3FC00000, 4'b0000, 6};
        vecs[12] = '{pk(32'h00000000), pk(32'h3FC00000), 3'd0, 32'h3FC00000, 4'b0000, 5};
        vecs[13] = '{{1'b1, 8'd1, 1'b1, 23'h400000}, {1'b0, 8'd1, 1'b1, 23'd0}, 3'd0,
                     32'h80000000, 4'b0101, 0};

        rst_i = 1'b1; start_i = 1'b0; pre_a_i = '0; pre_b_i = '0; exception_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("reset_ready", ready_o, 1);
        check("reset_done", done_o, 0);
        check("reset_result", result_o, 0);
        check("reset_flags", {overflow_o, underflow_o, invalid_o, inexact_o}, 0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].code, 1'b0, res, flg, lat, ok);
            check($sformatf("vec%0d_done_seen", i), ok, 1);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_flags", i), flg, vecs[i].flg);
            if (vecs[i].lat != 0) check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Long normalisation with start pulses arriving while busy
        run_op(pk(32'h3F800000), pk(32'hBF7FFFFF), 3'd0, 1'b1, res, flg, lat, ok);
        check("busy_done_seen", ok, 1);
        check("busy_result", res, 32'h33800000);
        check("busy_flags", flg, 4'b0000);
        check("busy_latency", lat, 29);
        extra = 0;
        repeat (5) begin @(posedge clk_i); #1; if (done_o) extra++; end
        check("busy_no_extra_done", extra, 0);

        // Reset in the middle of the same long operation
        @(negedge clk_i);
        pre_a_i = pk(32'h3F800000); pre_b_i = pk(32'hBF7FFFFF); exception_i = 3'd0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        extra = 0;
        repeat (9) begin @(posedge clk_i); #1; if (done_o) extra++; end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midrst_ready", ready_o, 1);
        check("midrst_done", done_o, 0);
        check("midrst_result", result_o, 0);
        repeat (40) begin @(posedge clk_i); #1; if (done_o) extra++; end
        check("midrst_no_done", extra, 0);

        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 3);
            fa = 23'($urandom);
            fb = 23'($urandom);
            case (mode)
                0: begin ea = 8'($urandom_range(0, 254)); eb = 8'($urandom_range(0, 254)); end
                1: begin
                    ea = 8'($urandom_range(2, 252));
                    t  = int'(ea) + int'($urandom_range(0, 4)) - 2;
                    eb = 8'(t);
                    if ($urandom_range(0, 1) == 1) fb = fa ^ 23'($urandom_range(0, 63));
                end
                2: begin ea = 8'($urandom_range(0, 6)); eb = 8'($urandom_range(0, 6)); end
                default: begin ea = 8'($urandom_range(240, 254)); eb = 8'($urandom_range(240, 254)); end
            endcase
            a = {1'($urandom), ea, (ea != 8'd0), fa};
            b = {1'($urandom), eb, (eb != 8'd0), fb};
            code = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(1, 7));
            exp_v = ref_model(a, b, code);
            run_op(a, b, code, 1'b0, res, flg, lat, ok);
            if (!ok) check($sformatf("rnd%0d_done_seen", i), ok, 1);
            check($sformatf("rnd%0d_result a=%0h b=%0h c=%0d", i, a, b, code), res, exp_v[35:4]);
            check($sformatf("rnd%0d_flags", i), flg, exp_v[3:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
